// File: rtl/gray_to_binary.sv
// gray_to_binary: registered Gray-to-binary converter with valid strobe and optional step checker
//
// Converts one WIDTH-bit Gray word per clock with one cycle of latency.
// Optional feature macro: GRAY2BIN_STEP_CHECK_EN (adds a non-unit Gray step detector).
//
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      qualifies gray this cycle
//   gray       in   WIDTH  Gray-coded input word
//   out_valid  out  1      registered copy of in_valid
//   binary     out  WIDTH  registered binary equivalent of the last accepted word
//   step_err   out  1      one-cycle pulse on a non-unit Gray step (0 when checker absent)
module gray_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic [WIDTH-1:0] binary,
    output logic             step_err
);
    logic [WIDTH-1:0] binary_d, binary_q;
    logic             out_valid_q;
    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        binary_d = '0;
        for (int i = 0; i < WIDTH; i++)
            binary_d[i] = ^(gray >> i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            binary_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid)
                binary_q <= binary_d;
        end
    end
    assign binary    = binary_q;
    assign out_valid = out_valid_q;
`ifdef GRAY2BIN_STEP_CHECK_EN
    logic [WIDTH-1:0] last_gray_q;
    logic             has_last_q;
    logic             step_err_d, step_err_q;
    // A legal Gray stream changes at most one bit per accepted word; repeats are allowed.
    always_comb step_err_d = in_valid && has_last_q && ($countones(gray ^ last_gray_q) > 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gray_q <= '0;
            has_last_q  <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            step_err_q <= step_err_d;
            if (in_valid) begin
                last_gray_q <= gray;
                has_last_q  <= 1'b1;
            end
        end
    end
    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_to_binary.sv
// tb_gray_to_binary: directed self-checking bench for gray_to_binary (WIDTH=4)
module tb_gray_to_binary;
`ifdef GRAY2BIN_STEP_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b1;
    logic [3:0] gray = 4'b1110;
    logic       out_valid;
    logic [3:0] binary;
    logic       step_err;
    int         checks = 0;
    int         errors = 0;

    gray_to_binary #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray),
        .out_valid(out_valid), .binary(binary), .step_err(step_err)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic r, input logic v, input logic [3:0] g);
        @(negedge clk);
        rst = r;
        in_valid = v;
        gray = g;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eb, input logic ev, input logic es);
        checks++;
        assert (binary === eb) else begin
            errors++;
            $error("FAIL %s binary: got %b expected %b", tag, binary, eb);
        end
        checks++;
        assert (out_valid === ev) else begin
            errors++;
            $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, ev);
        end
        checks++;
        assert (step_err === es) else begin
            errors++;
            $error("FAIL %s step_err: got %b expected %b", tag, step_err, es);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int k = 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    initial begin
        logic [3:0] pv;
        // reset held two cycles with in_valid=1
        cycle(1'b1, 1'b1, 4'b1110);
        cycle(1'b1, 1'b1, 4'b1110);
        chk("reset", 4'b0000, 1'b0, 1'b0);
        // directed vectors
        cycle(1'b0, 1'b1, 4'b1110); chk("d1110", 4'b1011, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0100); chk("d0100", 4'b0111, 1'b1, EN);
        cycle(1'b0, 1'b1, 4'b0111); chk("d0111", 4'b0101, 1'b1, EN);
        cycle(1'b0, 1'b1, 4'b1010); chk("d1010", 4'b1100, 1'b1, EN);
        cycle(1'b0, 1'b1, 4'b1000); chk("d1000", 4'b1111, 1'b1, 1'b0);
        // hold
        cycle(1'b0, 1'b1, 4'b1010); chk("h1010", 4'b1100, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'b0101); chk("hold1", 4'b1100, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'b0011); chk("hold2", 4'b1100, 1'b0, 1'b0);
        // exhaustive, codes in ascending order after a reset
        cycle(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            pv = 4'(i - 1);
            cycle(1'b0, 1'b1, 4'(i));
            chk($sformatf("ex%0d", i), model(4'(i)), 1'b1,
                EN && (i != 0) && ($countones(4'(i) ^ pv) > 1));
        end
        // out_valid follows in_valid one cycle later
        cycle(1'b0, 1'b0, 4'b0001); chk("ov0", model(4'b1111), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b1101); chk("ov1", 4'b1001, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'b1111); chk("ov2", 4'b1001, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b1100); chk("ov3", 4'b1000, 1'b1, 1'b0);
        // first word after reset never flags; wrap 1000->0000 is legal
        cycle(1'b1, 1'b1, 4'b0000);
        cycle(1'b0, 1'b1, 4'b1000); chk("first1000", 4'b1111, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0000); chk("wrap", 4'b0000, 1'b1, 1'b0);
        // step error and clean unit steps
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 1'b1, 4'b1110); chk("s1110", 4'b1011, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0100); chk("s0100", 4'b0111, 1'b1, EN);
        cycle(1'b0, 1'b1, 4'b0000); chk("s0000", 4'b0000, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0001); chk("s0001", 4'b0001, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0011); chk("s0011", 4'b0010, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0010); chk("s0010", 4'b0011, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0010); chk("repeat", 4'b0011, 1'b1, 1'b0);
        // mid-stream reset drops the in-flight word
        cycle(1'b0, 1'b1, 4'b1010); chk("m1010", 4'b1100, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'b0111); chk("midrst", 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'b0111); chk("postrst", 4'b0000, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
